// File: rtl/clk_enable_gen_if.sv
// Control/status bundle for clk_enable_gen: divisor write port, run enables,
// and the per-channel tick/square/pending outputs.
interface clk_enable_gen_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
);
    logic [CHANNELS-1:0] en;
    logic                div_wr;
    logic [CH_W-1:0]     div_ch;
    logic [WIDTH-1:0]    div_val;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] sq;
    logic [CHANNELS-1:0] pending;

    modport master (
        output en, div_wr, div_ch, div_val,
        input  tick, sq, pending
    );

    modport slave (
        input  en, div_wr, div_ch, div_val,
        output tick, sq, pending
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: each channel divides clk by a
// runtime divisor, emitting a tick strobe and a square wave without runt periods.
module clk_enable_ch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pending_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             en_q;
    logic             run;
    logic             term;

    // The edge on which en rises behaves like a fresh write, so the first period
    // after enabling is a full D cycles long.
    assign run  = en_i && en_q && (div_q != '0);
    assign term = run && (cnt_q == div_q - WIDTH'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (!run || term) begin
            cnt_d = '0;
            if (term) begin
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end
            // A boundary (or idle) edge: a write lands directly, else apply the deferred divisor.
            if (wr_i) begin
                div_d  = val_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            if (wr_i) begin
                pdiv_d = val_i;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= '0;
            pdiv_q <= '0;
            pend_q <= 1'b0;
            sq_q   <= 1'b0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
            en_q   <= en_i;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign pending_o = pend_q;
endmodule

module clk_enable_gen #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    clk_enable_gen_if.slave  bus
);
    logic [CHANNELS-1:0] wr_sel;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Out-of-range channel indices never match any lane, so they are dropped.
        assign wr_sel[i] = bus.div_wr && (bus.div_ch == CH_W'(i));

        clk_enable_ch #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (bus.en[i]),
            .wr_i      (wr_sel[i]),
            .val_i     (bus.div_val),
            .tick_o    (bus.tick[i]),
            .sq_o      (bus.sq[i]),
            .pending_o (bus.pending[i])
        );
    end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: reset, steady division, deferred and
// boundary writes, D=1/D=0, invalid channel, reset and enable-drop with pending.
module tb_clk_enable_gen;
    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic exp_tick, exp_sq;

    always #5 clk = ~clk;

    clk_enable_gen_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

    clk_enable_gen #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input int val);
        bus.div_wr  = 1'b1;
        bus.div_ch  = CH_W'(ch);
        bus.div_val = WIDTH'(val);
    endtask

    task automatic wr(input int ch, input int val);
        set_wr(ch, val);
        cyc();
        bus.div_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = '0;
        bus.div_wr = 1'b0;
        bus.div_ch = '0;
        bus.div_val = '0;
        cyc();
        cyc();
        chk("rst tick", 32'(bus.tick), 0);
        chk("rst sq", 32'(bus.sq), 0);
        chk("rst pending", 32'(bus.pending), 0);
        rst = 1'b0;

        // ch0 D=4: ticks every 4 edges after the write edge, sq period 8
        bus.en = 4'b0001;
        wr(0, 4);
        chk("t1 tick at write", 32'(bus.tick), 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("t1 tick k=%0d", k), 32'(bus.tick), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("t1 sq0 k=%0d", k), 32'(bus.sq[0]), (k / 4) % 2);
        end

        // ch1 D=10, deferred write of 3 landing at cnt 5
        bus.en = 4'b0011;
        wr(1, 10);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) set_wr(1, 3);
            cyc();
            bus.div_wr = 1'b0;
            chk($sformatf("t2 tick1 k=%0d", k), 32'(bus.tick[1]),
                (k == 10 || (k > 10 && (k - 10) % 3 == 0)) ? 1 : 0);
            chk($sformatf("t2 pend1 k=%0d", k), 32'(bus.pending[1]), (k >= 5 && k < 10) ? 1 : 0);
        end

        // ch2 D=1 then D=0 (written on a terminal edge, so one last tick)
        bus.en = 4'b0111;
        wr(2, 1);
        chk("t3 tick2 at write", 32'(bus.tick[2]), 0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) set_wr(2, 0);
            cyc();
            bus.div_wr = 1'b0;
            chk($sformatf("t3 tick2 k=%0d", k), 32'(bus.tick[2]), (k <= 5) ? 1 : 0);
            chk($sformatf("t3 sq2 k=%0d", k), 32'(bus.sq[2]), (k <= 5) ? k % 2 : 1);
        end

        // ch3 D=6 -> 2 written exactly on the terminal edge
        bus.en = 4'b1111;
        wr(3, 6);
        exp_sq = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) set_wr(3, 2);
            cyc();
            bus.div_wr = 1'b0;
            exp_tick = (k == 6 || (k > 6 && (k - 6) % 2 == 0));
            exp_sq = exp_sq ^ exp_tick;
            chk($sformatf("t4 tick3 k=%0d", k), 32'(bus.tick[3]), 32'(exp_tick));
            chk($sformatf("t4 sq3 k=%0d", k), 32'(bus.sq[3]), 32'(exp_sq));
            chk($sformatf("t4 pend3 k=%0d", k), 32'(bus.pending[3]), 0);
        end

        // reset mid-period with a pending divisor on ch0
        bus.en = 4'b1110;
        cyc();
        wr(0, 8);
        bus.en = 4'b1111;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) set_wr(0, 5);
            cyc();
            bus.div_wr = 1'b0;
            chk($sformatf("t5 pend0 k=%0d", k), 32'(bus.pending[0]), (k >= 2) ? 1 : 0);
            chk($sformatf("t5 tick0 k=%0d", k), 32'(bus.tick[0]), 0);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5 rst tick", 32'(bus.tick), 0);
        chk("t5 rst sq", 32'(bus.sq), 0);
        chk("t5 rst pending", 32'(bus.pending), 0);

        // writes to out-of-range channels must not touch any channel
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) set_wr(4, 1);
            if (k == 2) set_wr(5, 1);
            cyc();
            bus.div_wr = 1'b0;
            chk($sformatf("t5 idle tick k=%0d", k), 32'(bus.tick), 0);
            chk($sformatf("t5 idle pend k=%0d", k), 32'(bus.pending), 0);
            chk($sformatf("t5 idle sq k=%0d", k), 32'(bus.sq), 0);
        end

        // ch0 D=2, pending 5, en dropped, then re-raised
        wr(0, 2);
        exp_sq = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 3) set_wr(0, 5);
            bus.en[0] = (k < 4 || k >= 7);
            cyc();
            bus.div_wr = 1'b0;
            exp_tick = (k == 2 || k == 12 || k == 17);
            exp_sq = exp_sq ^ exp_tick;
            chk($sformatf("t6 tick0 k=%0d", k), 32'(bus.tick[0]), 32'(exp_tick));
            chk($sformatf("t6 sq0 k=%0d", k), 32'(bus.sq[0]), 32'(exp_sq));
            chk($sformatf("t6 pend0 k=%0d", k), 32'(bus.pending[0]), (k == 3) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised multi-channel programmable clock-enable generator for the VGA clocking path. Each channel divides `clk` by a runtime-written divisor and produces a one-cycle `tick` strobe and a toggling square wave `sq`. A divisor change on a running channel is deferred to the next period boundary, so no channel ever emits a runt period. The block supplies pixel-rate and derived-rate enables to the video timing logic from one system clock.

## Interface
- `WIDTH`, 32, divisor and counter width in bits
- `CHANNELS`, 4, number of independent channels
- `CH_W`, 2, width of channel index; must satisfy 2^CH_W >= CHANNELS
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  CHANNELS  per-channel run enable
- `div_wr`  in  1  divisor write strobe, sampled each rising edge
- `div_ch`  in  CH_W  target channel for the write
- `div_val`  in  WIDTH  divisor value D for the write
- `tick`  out  CHANNELS  registered one-cycle strobe at end of each D-cycle period
- `sq`  out  CHANNELS  registered square wave; toggles with each tick, period 2·D
- `pending`  out  CHANNELS  a written divisor is waiting for a period boundary

## Operation
- State per channel: `cnt[WIDTH]`, active divisor `div[WIDTH]`, pending divisor `pdiv[WIDTH]`, `pending` flag, `sq`, `tick`.
- Reset: all `cnt`, `div`, `pdiv` = 0; `tick`, `sq`, `pending` = 0. Channels are idle until programmed.
- A channel is running when `en[i]`=1 and `div`≠0. Otherwise it is idle: `cnt` is held at 0, `tick`=0, and `sq` holds its value.
- Terminal count: running and `cnt` == `div`-1. On that edge: `cnt`←0, `tick`←1, `sq`←~`sq`. On other running edges: `cnt`←`cnt`+1, `tick`←0.
- If `pending` is set at a terminal edge: `div`←`pdiv`, `pending`←0. `cnt`←0 as usual.
- Write (`div_wr`=1, `div_ch`<CHANNELS), channel idle: `div`←`div_val`, `cnt`←0, `pending`←0 on that edge.
- Write, channel running, edge is not terminal: `pdiv`←`div_val`, `pending`←1. A repeat write before the boundary overwrites `pdiv`; the last write wins.
- Write, channel running, edge is terminal: the tick fires with the old divisor, `div`←`div_val` directly, `pending`←0, and any older `pdiv` is discarded.
- Writes with `div_ch` >= CHANNELS are ignored. A write only affects its addressed channel.
- D=0 written: the channel becomes idle; `sq` holds.
- D=1: `tick` is held high continuously; `sq` toggles every cycle.
- `en[i]` falling while `pending` is set: `div`←`pdiv` on that edge, `pending`←0, `cnt`←0.
- Arithmetic: `cnt` compares against `div`-1 in WIDTH bits; `div`≠0 is guaranteed before the compare is used, so there is no underflow. `cnt` never exceeds `div`-1.

## Timing
- Writing D to an idle, enabled channel at edge E0: `cnt`=0 after E0. The first `tick` is high in the cycle after edge E0+D, and ticks repeat every D cycles.
- `tick` is exactly one cycle wide for D>=2.
- `sq` changes on the same edge that raises `tick`.
- Raising `en[i]` at edge E0 with `div`=D has the same timing as a write at E0.
- A deferred divisor takes effect at the first terminal edge after the write. The period ending at that edge keeps the old length; the next period has length D_new.
- `pending` rises on the edge after an accepted deferred write and falls on the applying edge.
- `rst` has priority over every other input. Reset mid-period clears all state on that edge; no tick is emitted.
- Channels are fully independent; there is no cross-channel latency.

## Test plan
- Reset, then write D=4 to ch0 with `en`=1 → `tick[0]` pulses every 4 cycles, first pulse 4 cycles after the write edge; `sq[0]` period 8; all other channels stay silent.
- ch1 running at D=10; write D=3 at `cnt`=5 → `pending[1]`=1 for 5 cycles, the current period completes at length 10, then ticks every 3 cycles; no tick spacing other than 10 or 3 appears.
- Write D=1 to ch2 → `tick[2]` constantly 1, `sq[2]` toggles every cycle; then write D=0 → tick stops on the next edge, `sq[2]` frozen.
- Write on the exact terminal edge of ch3 (D=6 → 2): the tick fires on that edge, following ticks every 2 cycles, `pending[3]` never rises. Also issue `div_ch`=CHANNELS with `CHANNELS`<2^CH_W → no state changes.
- Assert `rst` mid-period with `pending` set on ch0 → next cycle all `tick`/`sq`/`pending`=0; the channel stays idle until rewritten.
- Drop `en[0]` while running and `pending` is set → `tick[0]`=0, `sq[0]` held, `pending[0]` cleared; re-raising `en[0]` ticks with the new D after D cycles.
